// File: rtl/mem_disp_queue.sv
// Memory dispatch queue: in-order circular buffer between rename (multi-lane enqueue)
// and the memory block (multi-lane dispatch with prefix accept).

`ifndef MEMDQ_DISP_WID
`define MEMDQ_DISP_WID 4
`endif

package mem_disp_queue_pkg;
    typedef struct packed {
        logic [5:0]  rob_id;
        logic        is_store;
        logic [1:0]  size;
        logic [6:0]  dst_preg;
        logic [15:0] imm;
    } microOp_t;
endpackage

module mem_disp_queue
    import mem_disp_queue_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned ENQ_WID = 4,
    parameter int unsigned DEQ_WID = `MEMDQ_DISP_WID
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_squash_vld,
    output logic                              o_can_enq,
    input  logic [ENQ_WID-1:0]                i_enq_req,
    input  microOp_t [ENQ_WID-1:0]            i_enq_info,
    output logic [DEQ_WID-1:0]                o_disp_vld,
    output microOp_t [DEQ_WID-1:0]            o_disp_info,
    input  logic [DEQ_WID-1:0]                i_disp_acc,
    output logic [$clog2(DEPTH):0]            o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] count;
    logic [PW-1:0] free_cnt;
    logic [PW-1:0] enq_num;
    logic [PW-1:0] deq_num;
    logic [PW-1:0] rank [ENQ_WID];
    logic          enq_ok;
    logic          acc_bad;
    logic [DEQ_WID-1:0] acc_p1;

    microOp_t mem [DEPTH];

    assign o_count   = count;
    assign free_cnt  = PW'(DEPTH) - count;
    assign o_can_enq = free_cnt >= PW'(ENQ_WID);
    assign enq_ok    = o_can_enq && !i_squash_vld;

    // Per-lane compaction rank and total enqueue amount
    always_comb begin
        enq_num = '0;
        for (int k = 0; k < int'(ENQ_WID); k++) begin
            rank[k] = enq_num;
            if (i_enq_req[k]) enq_num = enq_num + PW'(1);
        end
    end

    // Dispatch window reads straight from storage: no enqueue bypass
    always_comb begin
        for (int i = 0; i < int'(DEQ_WID); i++) begin
            o_disp_vld[i]  = PW'(i) < count;
            o_disp_info[i] = mem[head[AW-1:0] + AW'(i)];
        end
    end

    // Dequeue amount = run of accepted valid lanes starting at lane 0
    always_comb begin
        logic run;
        run     = 1'b1;
        deq_num = '0;
        for (int i = 0; i < int'(DEQ_WID); i++) begin
            if (run && i_disp_acc[i] && o_disp_vld[i]) deq_num = deq_num + PW'(1);
            else run = 1'b0;
        end
    end

    assign acc_p1  = i_disp_acc + DEQ_WID'(1);
    assign acc_bad = (|(i_disp_acc & acc_p1)) || (|(i_disp_acc & ~o_disp_vld));

    // Payload storage is never reset
    always_ff @(posedge clk) begin
        for (int k = 0; k < int'(ENQ_WID); k++) begin
            if (enq_ok && i_enq_req[k]) begin
                mem[tail[AW-1:0] + AW'(rank[k])] <= i_enq_info[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (i_squash_vld) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + deq_num;
            tail  <= tail + (enq_ok ? enq_num : PW'(0));
            count <= count + (enq_ok ? enq_num : PW'(0)) - deq_num;
        end
    end

    // Accepts are ignored during squash, so only check them outside it
    a_acc_legal : assert property (@(posedge clk) disable iff (rst || i_squash_vld) !acc_bad)
        else $error("mem_disp_queue: illegal accept pattern %b (vld %b)", i_disp_acc, o_disp_vld);

endmodule

// File: tb/tb_mem_disp_queue.sv
// Directed self-checking bench for mem_disp_queue (DEPTH=16, 4 enqueue / 4 dispatch lanes).

module tb_mem_disp_queue;
    import mem_disp_queue_pkg::*;

    logic                 clk;
    logic                 rst;
    logic                 i_squash_vld;
    logic                 o_can_enq;
    logic [3:0]           i_enq_req;
    microOp_t [3:0]       i_enq_info;
    logic [3:0]           o_disp_vld;
    microOp_t [3:0]       o_disp_info;
    logic [3:0]           i_disp_acc;
    logic [4:0]           o_count;

    int total = 0;
    int bad   = 0;

    mem_disp_queue #(.DEPTH(16), .ENQ_WID(4), .DEQ_WID(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_squash_vld (i_squash_vld),
        .o_can_enq    (o_can_enq),
        .i_enq_req    (i_enq_req),
        .i_enq_info   (i_enq_info),
        .o_disp_vld   (o_disp_vld),
        .o_disp_info  (o_disp_info),
        .i_disp_acc   (i_disp_acc),
        .o_count      (o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic microOp_t mk(input logic [31:0] v);
        return microOp_t'(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_squash_vld = 1'b0;
        i_enq_req    = '0;
        i_disp_acc   = '0;
        for (int k = 0; k < 4; k++) i_enq_info[k] = mk(32'hDEAD_0000 + 32'(k));
    endtask

    task automatic enq4(input logic [31:0] base);
        i_enq_req = 4'b1111;
        for (int k = 0; k < 4; k++) i_enq_info[k] = mk(base + 32'(k));
    endtask

    task automatic chk_lanes(input string tag, input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_lane%0d", tag, i), 64'(o_disp_info[i]), 64'(base + 32'(i)));
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #2;
        chk("rst_count", 64'(o_count), 64'd0);
        chk("rst_vld", 64'(o_disp_vld), 64'd0);
        chk("rst_can_enq", 64'(o_can_enq), 64'd1);
        #1 rst = 1'b0;

        // Reset then full-width enqueue of A..D
        enq4(32'hA);
        tick();
        idle();
        chk("enq_count", 64'(o_count), 64'd4);
        chk("enq_vld", 64'(o_disp_vld), 64'hF);
        chk_lanes("enq", 32'hA, 4);

        // Add E,F then prefix-accept two
        i_enq_req = 4'b0011;
        i_enq_info[0] = mk(32'hE);
        i_enq_info[1] = mk(32'hF);
        tick();
        idle();
        chk("ef_count", 64'(o_count), 64'd6);
        i_disp_acc = 4'b0011;
        chk("legal_acc_flag", 64'(dut.acc_bad), 64'd0);
        tick();
        idle();
        chk("pfx_count", 64'(o_count), 64'd4);
        chk("pfx_lane0", 64'(o_disp_info[0]), 64'hC);
        chk("pfx_lane3", 64'(o_disp_info[3]), 64'hF);

        // Squash with simultaneous enqueue and accept
        i_squash_vld = 1'b1;
        enq4(32'h50);
        i_disp_acc = 4'b0001;
        tick();
        idle();
        chk("sq_count", 64'(o_count), 64'd0);
        chk("sq_vld", 64'(o_disp_vld), 64'd0);
        chk("sq_can_enq", 64'(o_can_enq), 64'd1);

        // Sparse enqueue: lanes 1 and 3 only
        i_enq_req = 4'b1010;
        i_enq_info[1] = mk(32'hX1_0001 & 32'h00FF_FFFF);
        i_enq_info[3] = mk(32'h0003_0003);
        tick();
        idle();
        chk("sparse_count", 64'(o_count), 64'd2);
        chk("sparse_vld", 64'(o_disp_vld), 64'h3);
        chk("sparse_lane1", 64'(o_disp_info[1]), 64'h0003_0003);

        // Illegal non-prefix accept, masked by squash so only the detector is observed
        i_squash_vld = 1'b1;
        i_disp_acc   = 4'b0101;
        #1;
        chk("illegal_acc_flag", 64'(dut.acc_bad), 64'd1);
        tick();
        idle();
        chk("ill_sq_count", 64'(o_count), 64'd0);

        // Fill to full from slot 0
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("fill%0d_can_enq", c), 64'(o_can_enq), 64'd1);
            enq4(32'h100 + 32'(4 * c));
            tick();
            idle();
        end
        chk("full_count", 64'(o_count), 64'd16);
        chk("full_can_enq", 64'(o_can_enq), 64'd0);

        // Full: enqueue refused even with a same-cycle dequeue
        enq4(32'h900);
        i_disp_acc = 4'b1111;
        tick();
        idle();
        chk("full_deq_count", 64'(o_count), 64'd12);
        chk("full_deq_can_enq", 64'(o_can_enq), 64'd1);
        chk("full_deq_lane0", 64'(o_disp_info[0]), 64'h104);

        // Enqueue across slot 15->0
        enq4(32'h110);
        tick();
        idle();
        chk("wrap_count", 64'(o_count), 64'd16);
        chk("wrap_tail_flag", 64'(dut.tail), 64'h14);
        for (int d = 0; d < 4; d++) begin
            chk_lanes($sformatf("drain%0d", d), 32'h104 + 32'(4 * d), 4);
            i_disp_acc = 4'b1111;
            tick();
            idle();
        end
        chk("drain_count", 64'(o_count), 64'd0);
        chk("drain_vld", 64'(o_disp_vld), 64'd0);

        // Asynchronous reset mid-operation discards contents
        enq4(32'h200);
        tick();
        idle();
        chk("pre_rst_count", 64'(o_count), 64'd4);
        rst = 1'b1;
        #1;
        chk("async_rst_count", 64'(o_count), 64'd0);
        chk("async_rst_vld", 64'(o_disp_vld), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("post_rst_count", 64'(o_count), 64'd0);
        enq4(32'h300);
        tick();
        idle();
        chk("post_rst_enq_count", 64'(o_count), 64'd4);
        chk_lanes("post_rst", 32'h300, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_disp_queue.md
MEM_DISP_QUEUE -- requirements
Module: mem_disp_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16: queue entries; power of two, at least 2*ENQ_WID.
REQ-002 SHALL have parameter ENQ_WID, default 4: rename-side enqueue lanes per cycle.
REQ-003 SHALL have parameter DEQ_WID, default `MEMDQ_DISP_WID: dispatch lanes per cycle toward the memory block.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-006 SHALL have port i_squash_vld  in  1  pipeline squash; flushes the queue.
REQ-007 SHALL have port o_can_enq  out  1  high when at least ENQ_WID entries are free.
REQ-008 SHALL have port i_enq_req  in  ENQ_WID  per-lane enqueue request.
REQ-009 SHALL have port i_enq_info  in  microOp_t[ENQ_WID]  per-lane uop payload.
REQ-010 SHALL have port o_disp_vld  out  DEQ_WID  per-lane dispatch valid toward the memory block.
REQ-011 SHALL have port o_disp_info  out  microOp_t[DEQ_WID]  per-lane dispatched uop, oldest on lane 0.
REQ-012 SHALL have port i_disp_acc  in  DEQ_WID  per-lane accept returned by the memory block.
REQ-013 SHALL have port o_count  out  $clog2(DEPTH)+1  current occupancy.

Function
REQ-014 SHALL be a circular buffer with head and tail pointers of $clog2(DEPTH)+1 bits; the MSB is the wrap flag.
REQ-015 SHALL treat the queue as empty when head==tail, and as full when the index bits are equal and the wrap flags differ.
REQ-016 SHALL drive o_can_enq = (DEPTH - o_count) >= ENQ_WID, combinationally from registered count only.
REQ-017 SHALL, when o_can_enq && !i_squash_vld, write each requesting lane k into slot tail+rank(k), where rank(k) is the number of set i_enq_req bits below k, and advance tail by popcount(i_enq_req).
REQ-018 SHALL drop i_enq_req when o_can_enq is low, with no partial enqueue.
REQ-019 SHALL present an entry on o_disp_vld no earlier than the cycle after it is written; there is no enqueue-to-dispatch bypass.
REQ-020 SHALL assert o_disp_vld[i] iff i < o_count, and drive o_disp_info[i] = entry[head+i] modulo DEPTH.
REQ-021 SHALL compute the dequeue amount n as the number of leading ones of i_disp_acc & o_disp_vld, starting at lane 0; head advances by n.
REQ-022 SHALL flag an assertion failure if i_disp_acc is not a contiguous prefix, or if it is set on a lane whose o_disp_vld is low.
REQ-023 SHALL update o_count next = o_count + enq_num - n when enqueue and dequeue occur in the same cycle; a full queue with n>0 still refuses enqueue that cycle because o_can_enq uses registered count.
REQ-024 SHALL handle pointer wrap-around transparently; slot index = pointer[$clog2(DEPTH)-1:0], and the wrap flag toggles on crossing DEPTH.
REQ-025 SHALL, on i_squash_vld, set head=tail=0 and count=0 at the next edge, ignoring same-cycle enqueue and accept; o_disp_vld is all zero the following cycle.
REQ-026 SHALL hold the payload of a dispatched-but-not-accepted entry stable until it is accepted or squashed.
REQ-027 SHALL NOT reset the payload storage; only pointers and count are reset.

Reset
REQ-028 SHALL, while rst is high, asynchronously clear head, tail and count to 0, giving o_count=0, o_disp_vld=0 and o_can_enq=1.
REQ-029 SHALL discard contents when rst is asserted mid-operation; the first cycle after deassertion behaves as empty.

Verification
REQ-030 SHALL cover reset then enqueue: after reset, i_enq_req=4'b1111 with uops A,B,C,D for one cycle -> next cycle o_count=4, o_disp_vld=4'b1111, lane0=A through lane3=D.
REQ-031 SHALL cover a prefix accept: queue holds A..F, i_disp_acc=4'b0011 -> next cycle o_count=4, lane0=C, lane3=F.
REQ-032 SHALL cover full and wrap: fill 16 entries, then o_can_enq=0; accept 4 -> o_can_enq=1; enqueue 4 more -> tail wrap flag toggled, o_count=16, dispatch order preserved across slot 15->0.
REQ-033 SHALL cover a sparse enqueue: i_enq_req=4'b1010 with lanes X1,X3 into an empty queue -> o_count=2, lane0=X1, lane1=X3.
REQ-034 SHALL cover squash with simultaneous enqueue and accept: i_squash_vld=1 with i_enq_req=4'b1111 and i_disp_acc=4'b0001 -> next cycle o_count=0, o_disp_vld=0, o_can_enq=1.
REQ-035 SHALL cover an illegal accept: i_disp_acc=4'b0101 -> the assertion fires.
